// File: rtl/pps_channel_bank.sv
// pps_channel_bank: a bank of N_CH pulse channels driven by one synchronised
// PPS input and programmed over the shared 8-bit register bus. Each channel
// divides the PPS, delays the selected edge by a 32-bit phase and then emits
// a pulse of programmable width and polarity. A channel also tracks an overrun
// when a firing edge arrives while it is still busy.
// Optional feature macro: PPS_BANK_READBACK_EN. When it is defined, o_data
// returns register and status contents. When it is undefined, o_data is tied
// to zero and the read path is left out of the design.
module pps_channel_bank #(
    parameter int         N_CH      = 8,
    parameter logic [7:0] BASE_ADDR = 8'h10,
    parameter int         CH_STRIDE = 16
) (
    input  logic            i_clk_10,
    input  logic            i_rst,
    input  logic [7:0]      i_addr,
    input  logic [7:0]      i_data,
    input  logic            i_wr,
    output logic [7:0]      o_data,
    input  logic            i_pps_raw,
    output logic [N_CH-1:0] o_ch
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DELAY = 2'd2,
        PULSE = 2'd3
    } ch_state_t;

    localparam int         SHIFT    = $clog2(CH_STRIDE);
    localparam logic [8:0] SPAN     = 9'(N_CH * CH_STRIDE);
    localparam logic [7:0] OFF_MASK = 8'(CH_STRIDE - 1);

    // Address decode shared by every channel. An access is a hit only when it
    // lands inside the bank and on one of the nine mapped offsets.
    logic [7:0] rel;
    logic [7:0] rel_off;
    logic [7:0] rel_ch;
    logic [3:0] off;
    logic       addr_hit;

    assign rel      = i_addr - BASE_ADDR;
    assign rel_off  = rel & OFF_MASK;
    assign rel_ch   = rel >> SHIFT;
    assign off      = rel_off[3:0];
    assign addr_hit = (i_addr >= BASE_ADDR) && ({1'b0, rel} < SPAN) && (rel_off <= 8'd8);

    logic sync1;
    logic sync2;
    logic sync3;
    logic pps_edge;

    // Synchronise the raw PPS, then turn its rising edge into a one-cycle strobe.
    always_ff @(posedge i_clk_10 or posedge i_rst) begin
        if (i_rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync3    <= 1'b0;
            pps_edge <= 1'b0;
        end else begin
            sync1    <= i_pps_raw;
            sync2    <= sync1;
            sync3    <= sync2;
            pps_edge <= sync2 & ~sync3;
        end
    end

    // Per-channel status bits: {overrun, pulse active, running}.
    logic [N_CH-1:0][2:0] status_all;

`ifdef PPS_BANK_READBACK_EN
    logic [N_CH-1:0][7:0] rd_word;
    logic [7:0]           rd_sel;
`endif

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic        sel;
        logic        ctrl_wr;
        logic        run;
        logic        pol;
        logic        ovr;
        logic        run_next;
        logic        first;
        logic        fire;
        logic        busy;
        logic        out_q;
        logic [2:0]  status;
        logic [7:0]  div_num;
        logic [7:0]  div_eff;
        logic [7:0]  div_cnt;
        logic [31:0] phase;
        logic [31:0] dly_cnt;
        logic [15:0] width;
        logic [15:0] wid_sh;
        logic [15:0] wid_cnt;
        ch_state_t   state;

        assign sel      = i_wr && addr_hit && (rel_ch == 8'(g));
        assign ctrl_wr  = sel && (off == 4'd0);
        // The FSM reacts to a RUN write in the same cycle the register takes it.
        assign run_next = ctrl_wr ? i_data[0] : run;
        assign div_eff  = (div_num == 8'd0) ? 8'd1 : div_num;
        assign busy     = (state == DELAY) || (state == PULSE);
        assign fire     = pps_edge && run_next && (state != IDLE) &&
                          (first || (({1'b0, div_cnt} + 9'd1) >= {1'b0, div_eff}));
        assign status   = {ovr, state == PULSE, state != IDLE};
        assign status_all[g] = status;

        // Programmable registers. STATUS and unmapped offsets ignore writes.
        always_ff @(posedge i_clk_10 or posedge i_rst) begin
            if (i_rst) begin
                run     <= 1'b0;
                pol     <= 1'b0;
                div_num <= 8'h00;
                phase   <= 32'h0;
                width   <= 16'h0;
            end else if (sel) begin
                case (off)
                    4'd0: begin
                        run <= i_data[0];
                        pol <= i_data[1];
                    end
                    4'd1: div_num        <= i_data;
                    4'd2: phase[7:0]     <= i_data;
                    4'd3: phase[15:8]    <= i_data;
                    4'd4: phase[23:16]   <= i_data;
                    4'd5: phase[31:24]   <= i_data;
                    4'd6: width[7:0]     <= i_data;
                    4'd7: width[15:8]    <= i_data;
                    default: ;
                endcase
            end
        end

        // PPS divider: the first edge after arming fires, then every div_eff-th edge.
        always_ff @(posedge i_clk_10 or posedge i_rst) begin
            if (i_rst) begin
                div_cnt <= 8'h00;
                first   <= 1'b1;
            end else if (state == IDLE) begin
                div_cnt <= 8'h00;
                first   <= 1'b1;
            end else if (pps_edge && run_next) begin
                if (fire) begin
                    div_cnt <= 8'h00;
                    first   <= 1'b0;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end
        end

        // Channel FSM. A fire latches phase and width, a busy fire only flags an overrun.
        always_ff @(posedge i_clk_10 or posedge i_rst) begin
            if (i_rst) begin
                state   <= IDLE;
                dly_cnt <= 32'h0;
                wid_sh  <= 16'h0;
                wid_cnt <= 16'h0;
                ovr     <= 1'b0;
            end else begin
                if (fire && busy) begin
                    ovr <= 1'b1;
                end else if (ctrl_wr && i_data[7]) begin
                    ovr <= 1'b0;
                end

                if (!run_next) begin
                    state <= IDLE;
                end else begin
                    case (state)
                        IDLE: state <= WAIT;
                        WAIT: begin
                            if (fire && (width != 16'h0)) begin
                                wid_sh <= width;
                                if (phase == 32'h0) begin
                                    state   <= PULSE;
                                    wid_cnt <= width;
                                end else begin
                                    state   <= DELAY;
                                    dly_cnt <= phase;
                                end
                            end
                        end
                        DELAY: begin
                            if (dly_cnt == 32'd1) begin
                                state   <= PULSE;
                                wid_cnt <= wid_sh;
                            end else begin
                                dly_cnt <= dly_cnt - 32'd1;
                            end
                        end
                        PULSE: begin
                            if (wid_cnt == 16'd1) begin
                                state <= WAIT;
                            end else begin
                                wid_cnt <= wid_cnt - 16'd1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end

        // Registered channel output, inverted when POL is set.
        always_ff @(posedge i_clk_10 or posedge i_rst) begin
            if (i_rst) begin
                out_q <= 1'b0;
            end else begin
                out_q <= (state == PULSE) ^ pol;
            end
        end

        assign o_ch[g] = out_q;

`ifdef PPS_BANK_READBACK_EN
        logic [7:0] rd_local;

        // This channel's byte for the current bus offset.
        always_comb begin
            rd_local = 8'h00;
            case (off)
                4'd0:    rd_local = {6'b0, pol, run};
                4'd1:    rd_local = div_num;
                4'd2:    rd_local = phase[7:0];
                4'd3:    rd_local = phase[15:8];
                4'd4:    rd_local = phase[23:16];
                4'd5:    rd_local = phase[31:24];
                4'd6:    rd_local = width[7:0];
                4'd7:    rd_local = width[15:8];
                4'd8:    rd_local = {5'b0, status};
                default: rd_local = 8'h00;
            endcase
        end

        assign rd_word[g] = rd_local;
`endif
    end

`ifdef PPS_BANK_READBACK_EN
    // Select the addressed channel's byte. Anything outside the map reads zero.
    always_comb begin
        rd_sel = 8'h00;
        for (int c = 0; c < N_CH; c++) begin
            if (addr_hit && (rel_ch == 8'(c))) begin
                rd_sel = rd_word[c];
            end
        end
    end

    // Registered read port: data follows the address by one cycle.
    always_ff @(posedge i_clk_10 or posedge i_rst) begin
        if (i_rst) begin
            o_data <= 8'h00;
        end else begin
            o_data <= rd_sel;
        end
    end
`else
    // Without a read port the status bits have no observer.
    logic unused_status;
    assign unused_status = ^status_all;
    assign o_data = 8'h00;
`endif

endmodule

// File: tb/tb_pps_channel_bank.sv
// tb_pps_channel_bank: directed and randomised checks of pps_channel_bank
// with 15 channels. A reference model derives the expected pulse windows and
// overrun flags from PPS edge times using plain arithmetic. Read-back
// expectations follow PPS_BANK_READBACK_EN.
module tb_pps_channel_bank;

    localparam int N_CH = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr;
    logic            pps_raw;
    logic [7:0]      addr;
    logic [7:0]      wdata;
    logic [7:0]      rdata;
    logic [N_CH-1:0] och;

    int cyc     = 0;
    int nvec    = 0;
    int nerr    = 0;
    int raw_off = -1;
    int pps_q[$];

    pps_channel_bank #(
        .N_CH     (N_CH),
        .BASE_ADDR(8'h10),
        .CH_STRIDE(16)
    ) dut (
        .i_clk_10 (clk),
        .i_rst    (rst),
        .i_addr   (addr),
        .i_data   (wdata),
        .i_wr     (wr),
        .o_data   (rdata),
        .i_pps_raw(pps_raw),
        .o_ch     (och)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Cycle n is the interval after the n-th rising clock edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Stop the run if it never reaches the summary line.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    // Expected bus read value: data is returned only when the read port exists.
    function automatic logic [7:0] rbExp(input logic [7:0] v);
`ifdef PPS_BANK_READBACK_EN
        return v;
`else
        return 8'h00 & v;
`endif
    endfunction

    // Move to the next falling edge. A PPS scheduled for cycle E rises at cycle E-3.
    task automatic stepCycle();
        @(negedge clk);
        if (pps_q.size() > 0 && cyc >= pps_q[0] - 3) begin
            pps_raw = 1'b1;
            raw_off = cyc + 5;
            void'(pps_q.pop_front());
        end else if (raw_off >= 0 && cyc >= raw_off) begin
            pps_raw = 1'b0;
            raw_off = -1;
        end
    endtask

    task automatic waitTo(input int t);
        while (cyc < t) stepCycle();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nvec++;
        assert (observed === expected) else begin
            nerr++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h cycle=%0d",
                   tag, observed, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d);
        stepCycle();
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        stepCycle();
        wr    = 1'b0;
    endtask

    task automatic readReg(input logic [7:0] a, output logic [7:0] d);
        stepCycle();
        addr = a;
        stepCycle();
        d = rdata;
    endtask

    task automatic expectRead(input string tag, input logic [7:0] a, input logic [7:0] v);
        logic [7:0] d;
        readReg(a, d);
        checkOutput(tag, 32'(d), 32'(rbExp(v)));
    endtask

    // Program one channel, drive a PPS train, and compare o_ch every cycle
    // against pulse windows predicted from the edge times.
    task automatic runScenario(input int ch, input int div, input int ph, input int wd,
                               input bit pol, input int nedge, input int gmin, input int gmax);
        int              edges[$];
        int              act_lo[$];
        int              act_hi[$];
        int              t;
        int              busy_end;
        int              div_eff;
        int              last;
        bit              ovr_exp;
        bit              act;
        logic [7:0]      base;
        logic [N_CH-1:0] exp_v;

        base = 8'h10 + 8'(ch * 16);
        applyStimulus(base + 8'd1, 8'(div));
        for (int i = 0; i < 4; i++) applyStimulus(base + 8'd2 + 8'(i), 8'(ph >> (8 * i)));
        for (int i = 0; i < 2; i++) applyStimulus(base + 8'd6 + 8'(i), 8'(wd >> (8 * i)));
        applyStimulus(base, {6'b0, pol, 1'b1});
        stepCycle();

        t = cyc + 6;
        for (int k = 0; k < nedge; k++) begin
            t += $urandom_range(gmax, gmin);
            edges.push_back(t);
            pps_q.push_back(t);
        end

        // Edge k fires when k is a multiple of the divisor. A firing edge is
        // accepted only after the previous delay and pulse have both finished.
        div_eff  = (div == 0) ? 1 : div;
        busy_end = -1;
        ovr_exp  = 1'b0;
        for (int k = 0; k < nedge; k++) begin
            if (k % div_eff == 0) begin
                if (edges[k] > busy_end) begin
                    act_lo.push_back(edges[k] + 2 + ph);
                    act_hi.push_back(edges[k] + 1 + ph + wd);
                    busy_end = edges[k] + ph + wd;
                end else begin
                    ovr_exp = 1'b1;
                end
            end
        end

        last = edges[nedge - 1] + ph + wd + 6;
        while (cyc < last) begin
            stepCycle();
            act = 1'b0;
            for (int i = 0; i < act_lo.size(); i++)
                if (cyc >= act_lo[i] && cyc <= act_hi[i]) act = 1'b1;
            exp_v = N_CH'(act ^ pol) << ch;
            checkOutput("och_wave", 32'(och), 32'(exp_v));
        end

        expectRead("status_end", base + 8'd8, {5'b0, ovr_exp, 1'b0, 1'b1});
        applyStimulus(base, 8'h80);
        expectRead("status_clear", base + 8'd8, 8'h00);
    endtask

    initial begin
        logic [7:0] vals[8];
        int         e1;
        int         e3;

        rst     = 1'b1;
        wr      = 1'b0;
        addr    = 8'h00;
        wdata   = 8'h00;
        pps_raw = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_och", 32'(och), 32'h0);
        checkOutput("reset_odata", 32'(rdata), 32'h0);
        rst = 1'b0;
        stepCycle();
        for (int a = 8'h10; a <= 8'h18; a++) expectRead("reset_reg", 8'(a), 8'h00);

        // Channel 14 register file: write every offset, then read back.
        $display("[TB] ch14 register readback");
        for (int i = 0; i < 8; i++) vals[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) applyStimulus(8'hF0 + 8'(i), vals[i]);
        applyStimulus(8'hF8, 8'hFF);
        expectRead("ch14_ctrl", 8'hF0, vals[0] & 8'h03);
        for (int i = 1; i < 8; i++) expectRead("ch14_reg", 8'hF0 + 8'(i), vals[i]);
        expectRead("ch14_status", 8'hF8, vals[0] & 8'h01);
        expectRead("unmapped_f9", 8'hF9, 8'h00);
        expectRead("unmapped_ff", 8'hFF, 8'h00);
        expectRead("unmapped_00", 8'h00, 8'h00);
        expectRead("unmapped_0f", 8'h0F, 8'h00);
        applyStimulus(8'hF0, 8'h00);

        // Directed pulse trains from the test plan.
        $display("[TB] ch0 div1 phase5 width3");
        runScenario(0, 1, 5, 3, 1'b0, 4, 60, 60);
        $display("[TB] ch2 div3 phase0 width1, both polarities");
        runScenario(2, 3, 0, 1, 1'b0, 7, 12, 12);
        runScenario(2, 3, 0, 1, 1'b1, 7, 12, 12);

        // Ch1 overrun, W1C clear, abort and re-arm.
        $display("[TB] ch1 overrun and abort");
        applyStimulus(8'h21, 8'd1);
        applyStimulus(8'h22, 8'd50);
        applyStimulus(8'h23, 8'd0);
        applyStimulus(8'h24, 8'd0);
        applyStimulus(8'h25, 8'd0);
        applyStimulus(8'h26, 8'd100);
        applyStimulus(8'h27, 8'd0);
        applyStimulus(8'h20, 8'h01);
        e1 = cyc + 8;
        pps_q.push_back(e1);
        pps_q.push_back(e1 + 60);
        waitTo(e1 + 51);
        checkOutput("ovr_before", 32'(och), 32'h0);
        stepCycle();
        checkOutput("ovr_first", 32'(och), 32'h2);
        waitTo(e1 + 100);
        expectRead("ovr_status", 8'h28, 8'h07);
        checkOutput("ovr_mid", 32'(och), 32'h2);
        applyStimulus(8'h20, 8'h81);
        expectRead("ovr_w1c", 8'h28, 8'h03);
        applyStimulus(8'h20, 8'h00);
        stepCycle();
        checkOutput("abort_och", 32'(och), 32'h0);
        expectRead("abort_status", 8'h28, 8'h00);
        applyStimulus(8'h20, 8'h01);
        e3 = cyc + 8;
        pps_q.push_back(e3);
        waitTo(e3 + 51);
        checkOutput("rearm_before", 32'(och), 32'h0);
        stepCycle();
        checkOutput("rearm_start", 32'(och), 32'h2);
        waitTo(e3 + 151);
        checkOutput("rearm_last", 32'(och), 32'h2);
        stepCycle();
        checkOutput("rearm_end", 32'(och), 32'h0);
        applyStimulus(8'h20, 8'h00);

        // Randomised channels, divisors, phases, widths, polarities and PPS spacing.
        $display("[TB] randomised scenarios");
        for (int s = 0; s < 6; s++) begin
            runScenario($urandom_range(N_CH - 1, 0), $urandom_range(3, 0),
                        $urandom_range(20, 0), $urandom_range(20, 1),
                        1'($urandom_range(1, 0)), $urandom_range(7, 4), 8, 40);
        end

        // Asynchronous reset in the middle of a pulse, with another channel idling high.
        $display("[TB] reset during pulse");
        applyStimulus(8'h11, 8'd1);
        applyStimulus(8'h12, 8'd5);
        applyStimulus(8'h16, 8'd40);
        applyStimulus(8'h40, 8'h02);
        applyStimulus(8'h10, 8'h01);
        e1 = cyc + 8;
        pps_q.push_back(e1);
        waitTo(e1 + 10);
        checkOutput("pre_reset", 32'(och), 32'h9);
        stepCycle();
        rst = 1'b1;
        #1;
        checkOutput("async_reset", 32'(och), 32'h0);
        stepCycle();
        rst = 1'b0;
        stepCycle();
        checkOutput("post_reset_och", 32'(och), 32'h0);
        for (int a = 8'h10; a <= 8'h19; a++) expectRead("post_reset_reg", 8'(a), 8'h00);
        expectRead("post_reset_ch3", 8'h40, 8'h00);
        expectRead("post_reset_0f", 8'h0F, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pps_channel_bank.md
# pps_channel_bank

Parametrised bank of N_CH PPS-derived pulse channels on the shared 8-bit SPI register bus. It replaces the fixed four-instance divider, channel-mux and main-memory arrangement with one block. Each channel divides the synchronised PPS, delays the selected edge by a 32-bit phase and emits a programmable-width pulse. Per-channel status, overrun detection and output polarity are new in this generation.

## Interface
- N_CH, 8, number of channels, 1..15
- BASE_ADDR, 8'h10, bus address of channel 0 register 0
- CH_STRIDE, 16, address stride between channels; power of two, ≥16; BASE_ADDR+N_CH*CH_STRIDE ≤ 256
- i_clk_10  in  1  system clock; the only clock
- i_rst  in  1  reset, asynchronous, active-high
- i_addr  in  8  bus address
- i_data  in  8  bus write data
- i_wr  in  1  write strobe, one cycle per byte
- o_data  out  8  registered read data
- i_pps_raw  in  1  asynchronous raw PPS
- o_ch  out  N_CH  channel outputs, registered

## Operation
- Register map per channel at offset from BASE_ADDR+ch*CH_STRIDE:
  - 0: CTRL. Bit0 RUN, bit1 POL (invert output), bit7 write-1-to-clear OVERRUN.
  - 1: DIV_NUM. 0 is treated as 1.
  - 2..5: PHASE[31:0], little-endian, in clock cycles.
  - 6..7: WIDTH[15:0], little-endian, in clock cycles.
  - 8: STATUS, read-only. Bit0 running, bit1 pulse active, bit2 OVERRUN (sticky).
  - Other offsets read 0 and ignore writes.
- All registers reset to 0.
- PPS conditioning: a 2-flop synchroniser plus a rising-edge detector produce a one-cycle strobe pps_edge shared by all channels.
- Channel FSM states:
  - IDLE. Entered on reset or RUN=0. Divider count cleared.
  - WAIT. Entered when RUN goes 0→1.
  - DELAY.
  - PULSE.
- Divider count: 8 bits. Incremented on every pps_edge while RUN=1, in any non-IDLE state.
- Firing edge: the first pps_edge after arming, then every DIV_NUM-th edge after it. On a firing edge the count resets to 0.
- At fire, PHASE and WIDTH are latched into shadow counters. Register writes during a pulse take effect at the next fire.
- WAIT + firing edge → DELAY. DELAY counts PHASE cycles, then → PULSE. PULSE counts WIDTH cycles, then → WAIT. WIDTH=0 → fire consumed with no pulse, return to WAIT.
- Firing edge while in DELAY or PULSE: the edge is dropped, OVERRUN is set, and the current pulse completes unchanged.
- RUN cleared in any state → IDLE on the next cycle, and the pulse is aborted.
- o_ch[i] = (state==PULSE) XOR POL, registered.
- Simultaneous OVERRUN set and write-1-to-clear in the same cycle: set wins.

## Timing
- Reset: o_ch = 0, o_data = 0, all FSMs in IDLE.
- i_pps_raw rising edge sampled at clock edge 0 → pps_edge high in cycle 2.
- Firing pps_edge in cycle E → o_ch active from cycle E+2+PHASE through E+1+PHASE+WIDTH inclusive, i.e. exactly WIDTH cycles.
- Write: register updated on the cycle after i_wr. A CTRL RUN 0→1 write enters WAIT on that same cycle, so a pps_edge in the following cycle is counted.
- Read: o_data is valid one cycle after i_addr. It holds the last value when the address is unchanged.
- Counters never wrap. PHASE = 2^32-1 is legal. The DELAY counter is 32 bits; the divider compares 8 bits.
- Async reset during PULSE: o_ch drops immediately to 0, regardless of POL.

## Configuration
- PPS_BANK_READBACK_EN
  - Defined: all registers and STATUS are readable per the map.
  - Undefined: o_data is constant 0, and the read mux and registers are removed. Channel behaviour, including OVERRUN tracking, is otherwise identical.

## Test plan
- Ch0: DIV_NUM=1, PHASE=5, WIDTH=3, RUN=1; PPS rises at cycle 100 (pps_edge at 102) → o_ch[0] high on cycles 109–111 only. Repeats on every PPS.
- Ch2: DIV_NUM=3, PHASE=0, WIDTH=1; 7 PPS edges → pulses on edges 1, 4, 7. Ch2 with POL=1 → output idles high and pulses low.
- Ch1: PHASE=50, WIDTH=100; PPS every 60 cycles → second edge dropped, STATUS=0x07 while pulse active. Write CTRL=0x81 → STATUS bit2 clears.
- Mid-pulse, write CTRL=0 → o_ch drops on the next cycle, STATUS=0x00. Re-arm → next PPS fires.
- Mid-pulse, assert i_rst → o_ch=0 immediately. After release all registers read 0 (READBACK_EN) and unmapped addresses read 0.
- N_CH=15, BASE_ADDR=0x10: write and read back every register of ch14 (0xF0–0xF8) → values match. Macro undefined → o_data stays 0.
